// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding, counter sizing and idle level for the PISO transmitter
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

  // Wide enough to hold 0..n so the terminal value n-1 always fits, including n=1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - bit position counter with clear, enable and terminal flag at N-1
module piso_bit_counter #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  // Saturates at N-1; the next load clears it for the following word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == W'(N - 1));

endmodule

// File: rtl/piso_shift_register_nbit.sv
// rtl/piso_shift_register_nbit.sv - parallel-in serial-out transmitter; optional trailing parity bit under PISO_PARITY_EN
module piso_shift_register_nbit
  import piso_pkg::*;
#(
  parameter int   n          = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [n-1:0] I,
  input  logic         shift_en,
  output logic         ready,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         done
);

  localparam int CW = cnt_width(n);

  piso_state_e  state, state_d;
  logic [n-1:0] sr, sr_d;
  logic         cnt_clear, cnt_en, tc;
  logic         done_d, out_bit;
`ifdef PISO_PARITY_EN
  logic         par_q, par_d;
`endif

  piso_bit_counter #(.N(n), .W(CW)) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (tc)
  );

  always_comb begin
    state_d   = state;
    sr_d      = sr;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    done_d    = 1'b0;
`ifdef PISO_PARITY_EN
    par_d     = par_q;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          sr_d      = I;
          cnt_clear = 1'b1;
          state_d   = SHIFT;
`ifdef PISO_PARITY_EN
          par_d     = ^I;
`endif
        end
      end
      SHIFT: begin
        if (shift_en) begin
          cnt_en = 1'b1;
          sr_d   = MSB_FIRST ? (sr << 1) : (sr >> 1);
          if (tc) begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (shift_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    out_bit = MSB_FIRST ? sr_d[n-1] : sr_d[0];
  end

  // Outputs are registered from the next-state view so the first bit appears one cycle after load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sr           <= '0;
      ready        <= 1'b1;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      sr           <= sr_d;
      ready        <= (state_d == IDLE);
      serial_valid <= (state_d != IDLE);
      done         <= done_d;
      if (state_d == SHIFT) begin
        serial_out <= out_bit;
`ifdef PISO_PARITY_EN
      end else if (state_d == PARITY) begin
        serial_out <= par_d;
`endif
      end else begin
        serial_out <= IDLE_LEVEL;
      end
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule
